muldiv_unit: RTL and testbench

Iterative multiply/divide engine and controller for the execute stage of the 5-stage MIPS pipeline. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU one bit per cycle with a shift-add or restoring-division datapath. It stalls the pipeline through the hazard unit while an operation is in flight, and services MTHI/MTLO writes. The main ALU is unaffected; this block is a separate shared resource sequenced alongside it.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one bit per cycle, WIDTH+2 stall cycles per op.
// Latency: start edge, WIDTH iteration edges, one FINISH edge; stallE holds the pipeline while busy.
// Backpressure: a new start is sampled only in IDLE; cancelE aborts RUN/FINISH without touching HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic [WIDTH-1:0] wdataE,
    input  logic             cancelE,
    output logic             stallE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Operand magnitudes; opE[0]=0 selects the signed flavours.
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_signed = ~opE[0];
    assign w_a_neg  = w_signed & srcaE[WIDTH-1];
    assign w_b_neg  = w_signed & srcbE[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~srcaE + 1'b1) : srcaE;
    assign w_b_mag  = w_b_neg ? (~srcbE + 1'b1) : srcbE;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_rem   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_rem - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH] ? {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    logic [2*WIDTH-1:0] w_prod;

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_dz) begin
                // Divide by zero reports all-ones quotient and the untouched dividend.
                w_hi_res = r_orig;
                w_lo_res = '1;
            end else begin
                w_lo_res = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
                w_hi_res = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_orig    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (startE) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_div     <= opE[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dz      <= opE[1] & (srcbE == '0);
                        r_orig    <= srcaE;
                        r_opnd    <= opE[1] ? w_b_mag : w_a_mag;
                        r_acc     <= opE[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                    end else begin
                        if (mthiE) r_hi <= wdataE;
                        if (mtloE) r_lo <= wdataE;
                    end
                end
                S_RUN: begin
                    if (cancelE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!cancelE) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stallE = ((r_state == S_IDLE) & startE) | r_busy;
    assign busy   = r_busy;
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pairs are queued at issue and checked when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'b00;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        mthiE = 1'b0;
    logic        mtloE = 1'b0;
    logic [31:0] wdataE = '0;
    logic        cancelE = 1'b0;
    logic        stallE, busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic prev_done = 1'b0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
        .mthiE(mthiE), .mtloE(mtloE), .wdataE(wdataE), .cancelE(cancelE),
        .stallE(stallE), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse retires one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h required no done", hi, lo);
            end else begin
                chk("result_hi_lo", {hi, lo}, exp_q.pop_front());
            end
        end
        prev_done = done;
    end

    // Called at negedge+1; returns at negedge+1 of the first non-stalled (done) cycle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int cnt;
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        exp_q.push_back({ehi, elo});
        #1;
        cnt = 0;
        while (stallE === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1 startE = 1'b0;
            @(negedge clk); #1;
        end
        chk({name, "_stall_cycles"}, 64'(cnt), 64'd34);
    endtask

    initial begin
        logic [31:0] phi, plo;
        int dsnap;

        // Reset state
        #12;
        chk("reset_hi_lo", {hi, lo}, 64'd0);
        chk("reset_busy_done_stall", {61'd0, busy, done, stallE}, 64'd0);
        @(negedge clk); rst = 1'b1;

        // MTHI then MTLO in IDLE
        @(negedge clk); mthiE = 1'b1; wdataE = 32'hA5A5A5A5; #1;
        chk("mthi_stall", {63'd0, stallE}, 64'd0);
        @(posedge clk); #1 mthiE = 1'b0;
        chk("mthi_hi", {hi, lo}, {32'hA5A5A5A5, 32'h0});
        @(negedge clk); mtloE = 1'b1; wdataE = 32'h5A5A5A5A; #1;
        chk("mtlo_stall", {63'd0, stallE}, 64'd0);
        @(posedge clk); #1 mtloE = 1'b0;
        chk("mtlo_lo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});

        // Back-to-back operations, each started in the previous done cycle
        @(negedge clk); #1;
        do_op("mult_neg3x7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult_minxmin",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        do_op("div_neg7by2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_7byneg2",   2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        do_op("divu_100by7",   2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        do_op("div_overflow",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        do_op("divu_by_zero",  2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
        do_op("div_by_zero",   2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);

        // Start together with MTHI (start wins), then MTHI while busy is ignored
        phi = hi;
        startE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd6; mthiE = 1'b1; wdataE = 32'hDEADBEEF;
        exp_q.push_back({32'd0, 32'd30});
        @(posedge clk); #1 startE = 1'b0;
        chk("start_beats_mthi", {32'd0, hi}, {32'd0, phi});
        repeat (3) @(posedge clk);
        #1 chk("mthi_while_busy", {32'd0, hi}, {32'd0, phi});
        mthiE = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("mult_5x6_idle", {63'd0, busy}, 64'd0);

        // Cancel mid-run: no write, no done
        @(negedge clk);
        phi = hi; plo = lo; dsnap = n_done;
        startE = 1'b1; opE = 2'b00; srcaE = 32'd3; srcbE = 32'd3;
        @(posedge clk); #1 startE = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); cancelE = 1'b1;
        @(posedge clk); #1 cancelE = 1'b0;
        chk("cancel_idle", {62'd0, busy, stallE}, 64'd0);
        repeat (40) @(posedge clk);
        #1 chk("cancel_hi_lo_kept", {hi, lo}, {phi, plo});
        chk("cancel_no_done", 64'(n_done - dsnap), 64'd0);

        // Asynchronous reset mid-run
        @(negedge clk);
        startE = 1'b1; opE = 2'b00; srcaE = 32'd9; srcbE = 32'd9;
        @(posedge clk); #1 startE = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("async_rst_hi_lo", {hi, lo}, 64'd0);
        chk("async_rst_busy", {62'd0, busy, done}, 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("rst_no_done", {hi, lo}, 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
